// File: rtl/idex_register.sv
// ID/EX pipeline register with flush-to-bubble and async reset.
// Optional hold input Stall_E when IDEX_STALL_EN is defined.
module idex_register #(
  parameter logic [31:0] FLUSH_PC = 32'h2A2A_2A2A
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Flush_E,
`ifdef IDEX_STALL_EN
  input  logic        Stall_E,
`endif
  input  logic        REG_W_En_D,
  input  logic        MEM_W_En_D,
  input  logic        Jump_En_D,
  input  logic        Branch_En_D,
  input  logic [2:0]  MEM_Control_D,
  input  logic [3:0]  ALU_Control_D,
  input  logic        Branch_Src_Sel_D,
  input  logic        ALU_SrcA_Sel_D,
  input  logic        ALU_SrcB_Sel_D,
  input  logic [1:0]  Result_Src_Sel_D,
  input  logic [4:0]  RD_D,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [31:0] REG_R_Data1_D,
  input  logic [31:0] REG_R_Data2_D,
  input  logic [31:0] Imm_Ext_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] PC_Plus_4_D,
  output logic        REG_W_En_E,
  output logic        MEM_W_En_E,
  output logic        Jump_En_E,
  output logic        Branch_En_E,
  output logic [2:0]  MEM_Control_E,
  output logic [3:0]  ALU_Control_E,
  output logic        Branch_Src_Sel_E,
  output logic        ALU_SrcA_Sel_E,
  output logic        ALU_SrcB_Sel_E,
  output logic [1:0]  Result_Src_Sel_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] REG_R_Data1_E,
  output logic [31:0] REG_R_Data2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [31:0] PC_E,
  output logic [31:0] PC_Plus_4_E
);

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    logic        jump;
    logic        branch;
    logic [2:0]  mem_ctl;
    logic [3:0]  alu_ctl;
    logic        br_src;
    logic        src_a;
    logic        src_b;
    logic [1:0]  res_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } idex_t;

  // Bubble: every enable low, PCs carry a recognisable marker.
  localparam idex_t BUBBLE = '{
    pc:      FLUSH_PC,
    pc4:     FLUSH_PC,
    default: '0
  };

  idex_t w_d;
  idex_t w_nxt;
  idex_t r_q;

  assign w_d = '{
    reg_w:   REG_W_En_D,
    mem_w:   MEM_W_En_D,
    jump:    Jump_En_D,
    branch:  Branch_En_D,
    mem_ctl: MEM_Control_D,
    alu_ctl: ALU_Control_D,
    br_src:  Branch_Src_Sel_D,
    src_a:   ALU_SrcA_Sel_D,
    src_b:   ALU_SrcB_Sel_D,
    res_sel: Result_Src_Sel_D,
    rd:      RD_D,
    rs1:     RS1_D,
    rs2:     RS2_D,
    rdata1:  REG_R_Data1_D,
    rdata2:  REG_R_Data2_D,
    imm:     Imm_Ext_D,
    pc:      PC_D,
    pc4:     PC_Plus_4_D
  };

  always_comb begin
    w_nxt = w_d;
    if (Flush_E) begin
      w_nxt = BUBBLE;
    end
`ifdef IDEX_STALL_EN
    else if (Stall_E) begin
      w_nxt = r_q;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= BUBBLE;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign REG_W_En_E       = r_q.reg_w;
  assign MEM_W_En_E       = r_q.mem_w;
  assign Jump_En_E        = r_q.jump;
  assign Branch_En_E      = r_q.branch;
  assign MEM_Control_E    = r_q.mem_ctl;
  assign ALU_Control_E    = r_q.alu_ctl;
  assign Branch_Src_Sel_E = r_q.br_src;
  assign ALU_SrcA_Sel_E   = r_q.src_a;
  assign ALU_SrcB_Sel_E   = r_q.src_b;
  assign Result_Src_Sel_E = r_q.res_sel;
  assign RD_E             = r_q.rd;
  assign RS1_E            = r_q.rs1;
  assign RS2_E            = r_q.rs2;
  assign REG_R_Data1_E    = r_q.rdata1;
  assign REG_R_Data2_E    = r_q.rdata2;
  assign Imm_Ext_E        = r_q.imm;
  assign PC_E             = r_q.pc;
  assign PC_Plus_4_E      = r_q.pc4;

endmodule

// File: tb/tb_idex_register.sv
// Bench for idex_register: edge-level model plus literal checks.
// Stall checks are compiled in when IDEX_STALL_EN is defined.
module tb_idex_register;

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    logic        jump;
    logic        branch;
    logic [2:0]  mem_ctl;
    logic [3:0]  alu_ctl;
    logic        br_src;
    logic        src_a;
    logic        src_b;
    logic [1:0]  res_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } bun_t;

  localparam logic [31:0] MARK = 32'h2A2A_2A2A;

  logic CLK = 1'b0;
  logic RST;
  logic Flush_E;
  logic Stall_E;
  bun_t d;
  bun_t q;
  bun_t bubble;
  bun_t exp_q;
  bun_t held;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  idex_register dut (
    .CLK              (CLK),
    .RST              (RST),
    .Flush_E          (Flush_E),
`ifdef IDEX_STALL_EN
    .Stall_E          (Stall_E),
`endif
    .REG_W_En_D       (d.reg_w),
    .MEM_W_En_D       (d.mem_w),
    .Jump_En_D        (d.jump),
    .Branch_En_D      (d.branch),
    .MEM_Control_D    (d.mem_ctl),
    .ALU_Control_D    (d.alu_ctl),
    .Branch_Src_Sel_D (d.br_src),
    .ALU_SrcA_Sel_D   (d.src_a),
    .ALU_SrcB_Sel_D   (d.src_b),
    .Result_Src_Sel_D (d.res_sel),
    .RD_D             (d.rd),
    .RS1_D            (d.rs1),
    .RS2_D            (d.rs2),
    .REG_R_Data1_D    (d.rdata1),
    .REG_R_Data2_D    (d.rdata2),
    .Imm_Ext_D        (d.imm),
    .PC_D             (d.pc),
    .PC_Plus_4_D      (d.pc4),
    .REG_W_En_E       (q.reg_w),
    .MEM_W_En_E       (q.mem_w),
    .Jump_En_E        (q.jump),
    .Branch_En_E      (q.branch),
    .MEM_Control_E    (q.mem_ctl),
    .ALU_Control_E    (q.alu_ctl),
    .Branch_Src_Sel_E (q.br_src),
    .ALU_SrcA_Sel_E   (q.src_a),
    .ALU_SrcB_Sel_E   (q.src_b),
    .Result_Src_Sel_E (q.res_sel),
    .RD_E             (q.rd),
    .RS1_E            (q.rs1),
    .RS2_E            (q.rs2),
    .REG_R_Data1_E    (q.rdata1),
    .REG_R_Data2_E    (q.rdata2),
    .Imm_Ext_E        (q.imm),
    .PC_E             (q.pc),
    .PC_Plus_4_E      (q.pc4)
  );

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic bun_t rnd();
    bun_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  // Model: what each edge must leave in the register, from the rules.
  always @(posedge CLK) begin
    if (RST || Flush_E) exp_q = bubble;
`ifdef IDEX_STALL_EN
    else if (Stall_E) exp_q = exp_q;
`endif
    else exp_q = d;
  end

  // Compare every cycle; reset held high overrides whatever the edge said.
  always @(negedge CLK) begin
    if (RST) chk("cyc_rst", q, bubble);
    else chk("cyc", q, exp_q);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bubble = '0;
    bubble.pc = MARK;
    bubble.pc4 = MARK;
    exp_q = bubble;
    Flush_E = 1'b0;
    Stall_E = 1'b0;
    RST = 1'b1;
    d = rnd();
    d.reg_w = 1'b1;
    d.mem_w = 1'b1;
    #1;
    chk("rst_now_regw", {191'd0, q.reg_w}, 192'd0);
    chk("rst_now_memw", {191'd0, q.mem_w}, 192'd0);
    chk("rst_now_pc", {160'd0, q.pc}, {160'd0, 32'h2A2A_2A2A});
    chk("rst_now_pc4", {160'd0, q.pc4}, {160'd0, 32'h2A2A_2A2A});
    chk("rst_now_rd1", {160'd0, q.rdata1}, 192'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      d = rnd();
    end
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      d = rnd();
    end
    // Flush with every enable asserted and a known PC.
    d.reg_w = 1'b1;
    d.mem_w = 1'b1;
    d.jump = 1'b1;
    d.branch = 1'b1;
    d.pc = 32'h0000_0100;
    d.pc4 = 32'h0000_0104;
    Flush_E = 1'b1;
    step();
    chk("fl_en", {188'd0, q.reg_w, q.mem_w, q.jump, q.branch}, 192'd0);
    chk("fl_pc", {160'd0, q.pc}, {160'd0, 32'h2A2A_2A2A});
    chk("fl_pc4", {160'd0, q.pc4}, {160'd0, 32'h2A2A_2A2A});
    chk("fl_imm", {160'd0, q.imm}, 192'd0);
    Flush_E = 1'b0;
    step();
    chk("post_fl_en", {188'd0, q.reg_w, q.mem_w, q.jump, q.branch},
        {188'd0, 4'hF});
    chk("post_fl_pc", {160'd0, q.pc}, {160'd0, 32'h0000_0100});
    chk("post_fl_pc4", {160'd0, q.pc4}, {160'd0, 32'h0000_0104});
    d = rnd();
    step();
    // Mid-operation reset, together with flush.
    d = rnd();
    RST = 1'b1;
    Flush_E = 1'b1;
    #1;
    chk("mid_rst", q, bubble);
    step();
    RST = 1'b0;
    Flush_E = 1'b0;
    d = rnd();
    d.rd = 5'd17;
    #1;
    chk("rel_hold", q, bubble);
    step();
    chk("rel_cap_rd", {187'd0, q.rd}, {187'd0, 5'd17});
`ifdef IDEX_STALL_EN
    held = d;
    Stall_E = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = rnd();
      step();
      chk("stall_hold", q, held);
    end
    Flush_E = 1'b1;
    step();
    chk("stall_flush", q, bubble);
    Flush_E = 1'b0;
    Stall_E = 1'b0;
`else
    held = d;
`endif
    // Mixed traffic with occasional flushes.
    for (int i = 0; i < 20; i++) begin
      d = rnd();
      Flush_E = ($urandom_range(0, 3) == 0);
      step();
    end
    Flush_E = 1'b0;
    step();
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idex_register.md
IDEX_REGISTER -- requirements
Module: idex_register

Interface
- REQ-001: Parameter FLUSH_PC, default 32'h2A2A_2A2A, is the marker value loaded into PC_E and PC_Plus_4_E on reset and flush.
- REQ-002: CLK  in  1  single clock; all state updates on its rising edge.
- REQ-003: RST  in  1  asynchronous, active-high reset.
- REQ-004: Flush_E  in  1  synchronous flush; loads a NOP bubble.
- REQ-005: REG_W_En_D/_E, MEM_W_En_D/_E, Jump_En_D/_E, Branch_En_D/_E  in/out  1 each  register-write, memory-write, jump and branch enables.
- REQ-006: MEM_Control_D/_E  in/out  3  memory access size/sign control.
- REQ-007: ALU_Control_D/_E  in/out  4  ALU operation select.
- REQ-008: Branch_Src_Sel_D/_E, ALU_SrcA_Sel_D/_E, ALU_SrcB_Sel_D/_E  in/out  1 each  branch-target source and ALU operand selects.
- REQ-009: Result_Src_Sel_D/_E  in/out  2  writeback result select.
- REQ-010: RD_D/_E, RS1_D/_E, RS2_D/_E  in/out  5 each  destination and source register indices.
- REQ-011: REG_R_Data1_D/_E, REG_R_Data2_D/_E  in/out  32 each  register-file read data.
- REQ-012: Imm_Ext_D/_E, PC_D/_E, PC_Plus_4_D/_E  in/out  32 each  extended immediate, PC, PC+4.

Function
- REQ-013: Each _E output SHALL be a flop driven directly from its _D input; no combinational path from input to output.
- REQ-014: With RST=0 and Flush_E=0, every _E output SHALL equal the corresponding _D value sampled at the previous rising CLK edge (latency 1 cycle).
- REQ-015: With RST=0 and Flush_E=1 at a rising edge, the register SHALL load the bubble state: all four enables 0; PC_E and PC_Plus_4_E = FLUSH_PC; all other outputs 0.
- REQ-016: Flush SHALL take effect on the edge where it is sampled high and SHALL affect only that cycle; normal capture resumes on the next edge with Flush_E=0.
- REQ-017: RST SHALL take priority over Flush_E; Flush_E SHALL take priority over normal capture.
- REQ-018: The bubble state SHALL never issue a register write, memory write, jump or branch, whatever the other outputs hold.

Reset
- REQ-019: RST=1 SHALL immediately, without waiting for a clock edge, force the bubble state of REQ-015 on all outputs.
- REQ-020: Outputs SHALL hold the bubble state while RST=1; the first capture of _D inputs SHALL be on the first rising edge with RST=0.
- REQ-021: Asserting RST mid-operation SHALL discard the captured instruction with no partial update.

Configuration
- REQ-022: Macro IDEX_STALL_EN defined: add input Stall_E (1 bit); with RST=0, Flush_E=0 and Stall_E=1, all outputs SHALL hold their values; Flush_E SHALL override Stall_E.
- REQ-023: IDEX_STALL_EN undefined: no Stall_E port; the register loads every cycle as in REQ-014.

Verification
- REQ-024: Drive RST=1 with random _D values -> all enables 0, PC_E=PC_Plus_4_E=0x2A2A2A2A, other outputs 0, before any clock edge.
- REQ-025: RST=0, Flush_E=0, random _D values for 5 cycles -> every _E output equals the previous cycle's _D value.
- REQ-026: All _D enables=1, PC_D=0x00000100, Flush_E=1 for one edge -> enables 0, PC_E=PC_Plus_4_E=0x2A2A2A2A; next edge with Flush_E=0 -> outputs equal _D values.
- REQ-027: RST=1 and Flush_E=1 together, then RST released -> bubble state held until the first edge after release, then normal capture.
- REQ-028: With IDEX_STALL_EN: Stall_E=1 for 2 cycles while _D values change -> outputs unchanged; Stall_E=1 with Flush_E=1 -> bubble state loaded.
